// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel gradient stage.
// Imported by the filter top level.
package sobel_pkg;

    localparam int unsigned DWIDTH_DEFAULT = 8;
    localparam int unsigned GRAD_W         = 11;
    localparam int unsigned CLAMP_VAL      = 255;

    typedef enum logic [0:0] {
        S_RUN,
        S_FLUSH
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: dout is the sample written DEPTH enables ago.
// Circular buffer, read-before-write at the same pointer.
module line_buffer #(
    parameter int unsigned DEPTH  = 720,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d;

    assign dout = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clock) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel magnitude over a raster-order pixel stream.
// One output per input pixel; border centers produce 0.
module sobel_filter
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH  = 720,
    parameter int unsigned HEIGHT = 540,
    parameter int unsigned DWIDTH = DWIDTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    output logic              fifo_in_rd_en,
    input  logic [DWIDTH-1:0] fifo_in_dout,
    input  logic              fifo_in_empty,
    output logic              fifo_out_wr_en,
    output logic [DWIDTH-1:0] fifo_out_din,
    input  logic              fifo_out_full
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned PW   = $clog2(NPIX + WIDTH + 1);
    localparam int unsigned CW   = $clog2(WIDTH);
    localparam int unsigned RW   = $clog2(HEIGHT + 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     pix_q, pix_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DWIDTH-1:0] win_q [3][3];
    logic [DWIDTH-1:0] win_d [3][3];
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic [DWIDTH-1:0] lb_mid_dout, lb_top_dout;
    logic              slot_free, accept, produce, border;

    logic signed [GRAD_W-1:0] gx, gy;
    logic [GRAD_W-1:0]        abs_x, abs_y, mag_full;
    logic [DWIDTH-1:0]        mag;

    assign slot_free      = !out_valid_q || !fifo_out_full;
    assign fifo_in_rd_en  = (state_q == S_RUN) && !fifo_in_empty && slot_free;
    assign accept         = fifo_in_rd_en;
    assign fifo_out_wr_en = out_valid_q && !fifo_out_full;
    assign fifo_out_din   = out_data_q;

    line_buffer #(.DEPTH(WIDTH), .DWIDTH(DWIDTH)) u_lb_mid (
        .clock (clock),
        .reset (reset),
        .en    (accept),
        .din   (fifo_in_dout),
        .dout  (lb_mid_dout)
    );

    line_buffer #(.DEPTH(WIDTH), .DWIDTH(DWIDTH)) u_lb_top (
        .clock (clock),
        .reset (reset),
        .en    (accept),
        .din   (lb_mid_dout),
        .dout  (lb_top_dout)
    );

    // Row 0 is the oldest line, column 2 the newest pixel.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_top_dout;
            win_d[1][2] = lb_mid_dout;
            win_d[2][2] = fifo_in_dout;
        end
    end

    function automatic logic signed [GRAD_W-1:0] ext(input logic [DWIDTH-1:0] p);
        return $signed({{(GRAD_W - DWIDTH){1'b0}}, p});
    endfunction

    // Computed on the post-shift window so the result loads with the accept.
    always_comb begin
        gx = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) + ext(win_d[2][0]));
        gy = (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) + ext(win_d[0][2]));
        abs_x    = gx[GRAD_W-1] ? -gx : gx;
        abs_y    = gy[GRAD_W-1] ? -gy : gy;
        mag_full = (abs_x + abs_y) >> 1;
        mag      = (mag_full > GRAD_W'(CLAMP_VAL)) ? DWIDTH'(CLAMP_VAL)
                                                   : mag_full[DWIDTH-1:0];
    end

    // Center is one row up and one column left of the accepted pixel.
    assign produce = (pix_q >= PW'(WIDTH + 1));
    assign border  = (col_q <= CW'(1)) || (row_q == RW'(1));

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (fifo_out_wr_en) begin
            out_valid_d = 1'b0;
        end
        unique case (state_q)
            S_RUN: begin
                if (accept) begin
                    pix_d = pix_q + PW'(1);
                    if (col_q == CW'(WIDTH - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (produce) begin
                        out_valid_d = 1'b1;
                        out_data_d  = border ? '0 : mag;
                    end
                    if (pix_q == PW'(NPIX - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Remaining centers are the last row plus the end of the one before.
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    if (pix_q == PW'(NPIX + WIDTH)) begin
                        pix_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        pix_d = pix_q + PW'(1);
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            pix_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clock) begin
        win_q <= win_d;
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Bench for sobel_filter: queue-modelled FIFOs on both sides and an
// arithmetic Sobel reference computed straight from the image array.
module tb_sobel_filter;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset;
    logic       fifo_in_rd_en;
    logic [7:0] fifo_in_dout;
    logic       fifo_in_empty;
    logic       fifo_out_wr_en;
    logic [7:0] fifo_out_din;
    logic       fifo_out_full;

    logic [7:0] inq[$];
    logic [7:0] outq[$];
    logic [7:0] expq[$];
    int         img[N];
    int         bubble_pct = 0;
    int         full_pct   = 0;
    bit         hold_full  = 1'b0;
    int         checks     = 0;
    int         failures   = 0;

    sobel_filter #(.WIDTH(W), .HEIGHT(H), .DWIDTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_rd_en  (fifo_in_rd_en),
        .fifo_in_dout   (fifo_in_dout),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_out_wr_en (fifo_out_wr_en),
        .fifo_out_din   (fifo_out_din),
        .fifo_out_full  (fifo_out_full)
    );

    initial forever #5 clock = ~clock;

    // Upstream FWFT FIFO and downstream sink; inputs change just after rising edges.
    initial begin
        fifo_in_empty = 1'b1;
        fifo_in_dout  = 8'h00;
        fifo_out_full = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            fifo_in_empty = (inq.size() == 0) || (int'($urandom_range(0, 99)) < bubble_pct);
            fifo_in_dout  = (inq.size() != 0) ? inq[0] : 8'h00;
            fifo_out_full = hold_full || (int'($urandom_range(0, 99)) < full_pct);
            @(negedge clock);
            if (!reset) begin
                if (fifo_in_rd_en && !fifo_in_empty) void'(inq.pop_front());
                if (fifo_out_wr_en && !fifo_out_full) outq.push_back(fifo_out_din);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, limit 2000000");
        $fatal(1);
    end

    function automatic int px(int r, int c);
        return img[r * W + c];
    endfunction

    task automatic model_frame();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int gx, gy, m;
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    m = 0;
                end else begin
                    gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
                       - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
                    gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
                       - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
                    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
                    if (m > 255) m = 255;
                end
                expq.push_back(8'(m));
            end
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < N; i++) inq.push_back(8'(img[i]));
    endtask

    task automatic wait_outputs(input int n);
        int budget = 4000;
        while (outq.size() < n && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic wait_accepts(input int n, output int got);
        int budget = 1000;
        got = 0;
        while (got < n && budget > 0) begin
            @(negedge clock);
            budget--;
            if (fifo_in_rd_en) got++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (fifo_out_wr_en !== 1'b0 || fifo_out_din !== 8'h00 || fifo_in_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got wr=%b din=%0d rd=%b, expected 0 0 0",
                     fifo_out_wr_en, fifo_out_din, fifo_in_rd_en);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (fifo_out_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_wr: got %b expected 0", fifo_out_wr_en);
        end
    endtask

    task automatic test_flat();
        int got, gap;
        outq.delete();
        expq.delete();
        for (int i = 0; i < N; i++) img[i] = 100;
        model_frame();
        model_frame();
        load_frame();
        load_frame();
        wait_accepts(N, got);
        checks++;
        if (got !== N) begin
            failures++;
            $display("FAIL flat_accepts: got %0d expected %0d", got, N);
        end
        gap = 0;
        for (int b = 0; b < 50; b++) begin
            @(negedge clock);
            if (fifo_in_rd_en) break;
            gap++;
        end
        checks++;
        if (gap !== W + 1) begin
            failures++;
            $display("FAIL flat_flush_gap: got %0d cycles expected %0d", gap, W + 1);
        end
        wait_outputs(2 * N);
        checks++;
        if (outq.size() !== 2 * N) begin
            failures++;
            $display("FAIL flat_count: got %0d writes expected %0d", outq.size(), 2 * N);
        end
        for (int i = 0; i < expq.size(); i++) begin
            int g;
            g = (i < outq.size()) ? int'(outq[i]) : -1;
            checks++;
            if (g !== int'(expq[i])) begin
                failures++;
                $display("FAIL flat_pix[%0d]: got %0d expected %0d", i, g, expq[i]);
            end
        end
    endtask

    task automatic test_ramp();
        outq.delete();
        expq.delete();
        for (int i = 0; i < N; i++) img[i] = (i % W) * 10;
        model_frame();
        load_frame();
        wait_outputs(N);
        checks++;
        if (outq.size() !== N) begin
            failures++;
            $display("FAIL ramp_count: got %0d writes expected %0d", outq.size(), N);
        end
        for (int i = 0; i < expq.size(); i++) begin
            int g;
            g = (i < outq.size()) ? int'(outq[i]) : -1;
            checks++;
            if (g !== int'(expq[i])) begin
                failures++;
                $display("FAIL ramp_pix[%0d]: got %0d expected %0d", i, g, expq[i]);
            end
        end
        for (int c = 1; c < W - 1; c++) begin
            int g;
            g = (W + c < outq.size()) ? int'(outq[W + c]) : -1;
            checks++;
            if (g !== 40) begin
                failures++;
                $display("FAIL ramp_center_c%0d: got %0d expected 40", c, g);
            end
        end
    endtask

    task automatic test_gradient();
        outq.delete();
        expq.delete();
        for (int i = 0; i < N; i++) img[i] = ((i % W) < 2) ? 0 : 255;
        model_frame();
        load_frame();
        wait_outputs(N);
        checks++;
        if (outq.size() !== N) begin
            failures++;
            $display("FAIL grad_count: got %0d writes expected %0d", outq.size(), N);
        end
        for (int i = 0; i < expq.size(); i++) begin
            int g;
            g = (i < outq.size()) ? int'(outq[i]) : -1;
            checks++;
            if (g !== int'(expq[i])) begin
                failures++;
                $display("FAIL grad_pix[%0d]: got %0d expected %0d", i, g, expq[i]);
            end
        end
        for (int c = 1; c <= 2; c++) begin
            int g;
            g = (W + c < outq.size()) ? int'(outq[W + c]) : -1;
            checks++;
            if (g !== 255) begin
                failures++;
                $display("FAIL grad_clamp_c%0d: got %0d expected 255", c, g);
            end
        end
    endtask

    task automatic test_stall();
        int got;
        logic [7:0] held;
        outq.delete();
        expq.delete();
        for (int i = 0; i < N; i++) img[i] = ((i % W) < 2) ? 0 : 255;
        model_frame();
        load_frame();
        wait_accepts(6, got);
        checks++;
        if (got !== 6) begin
            failures++;
            $display("FAIL stall_accepts: got %0d expected 6", got);
        end
        hold_full = 1'b1;
        held = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i >= 1) begin
                checks++;
                if (fifo_out_wr_en !== 1'b0 || fifo_in_rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_cycle%0d: got wr=%b rd=%b expected 0 0",
                             i, fifo_out_wr_en, fifo_in_rd_en);
                end
            end
            if (i == 1) held = fifo_out_din;
            if (i >= 2) begin
                checks++;
                if (fifo_out_din !== held) begin
                    failures++;
                    $display("FAIL stall_data%0d: got %0d expected %0d", i, fifo_out_din, held);
                end
            end
        end
        hold_full = 1'b0;
        wait_outputs(N);
        checks++;
        if (outq.size() !== N) begin
            failures++;
            $display("FAIL stall_count: got %0d writes expected %0d", outq.size(), N);
        end
        for (int i = 0; i < expq.size(); i++) begin
            int g;
            g = (i < outq.size()) ? int'(outq[i]) : -1;
            checks++;
            if (g !== int'(expq[i])) begin
                failures++;
                $display("FAIL stall_pix[%0d]: got %0d expected %0d", i, g, expq[i]);
            end
        end
    endtask

    task automatic test_bubbles();
        outq.delete();
        expq.delete();
        bubble_pct = 50;
        full_pct   = 30;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
            model_frame();
            load_frame();
        end
        wait_outputs(2 * N);
        bubble_pct = 0;
        full_pct   = 0;
        repeat (4) @(negedge clock);
        checks++;
        if (outq.size() !== 2 * N) begin
            failures++;
            $display("FAIL bubble_count: got %0d writes expected %0d", outq.size(), 2 * N);
        end
        for (int i = 0; i < expq.size(); i++) begin
            int g;
            g = (i < outq.size()) ? int'(outq[i]) : -1;
            checks++;
            if (g !== int'(expq[i])) begin
                failures++;
                $display("FAIL bubble_pix[%0d]: got %0d expected %0d", i, g, expq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int got;
        for (int i = 0; i < 7; i++) inq.push_back(8'($urandom_range(0, 255)));
        wait_accepts(7, got);
        checks++;
        if (got !== 7) begin
            failures++;
            $display("FAIL midreset_accepts: got %0d expected 7", got);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (fifo_out_wr_en !== 1'b0 || fifo_out_din !== 8'h00 || fifo_in_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got wr=%b din=%0d rd=%b expected 0 0 0",
                     fifo_out_wr_en, fifo_out_din, fifo_in_rd_en);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        outq.delete();
        expq.delete();
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
        model_frame();
        load_frame();
        wait_outputs(N);
        checks++;
        if (outq.size() !== N) begin
            failures++;
            $display("FAIL midreset_count: got %0d writes expected %0d", outq.size(), N);
        end
        for (int i = 0; i < expq.size(); i++) begin
            int g;
            g = (i < outq.size()) ? int'(outq[i]) : -1;
            checks++;
            if (g !== int'(expq[i])) begin
                failures++;
                $display("FAIL midreset_pix[%0d]: got %0d expected %0d", i, g, expq[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_flat();
        test_ramp();
        test_gradient();
        test_stall();
        test_bubbles();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
